// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/stall logic.
package mips_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    MULDIV = 1'b1
  } stall_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Pipeline control outputs driven by the stall controller, as one bundle.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic mem_wb_write;
    logic id_ex_bubble;
    logic ex_mem_bubble;
    logic if_id_flush;
    logic muldiv_done;
  } hazard_ctrl_t;

  // No hazard: every stage advances.
  localparam hazard_ctrl_t CTRL_RUN     = hazard_ctrl_t'(9'b11111_000_0);
  // Data memory wait: whole pipeline frozen, nothing injected.
  localparam hazard_ctrl_t CTRL_FREEZE  = hazard_ctrl_t'(9'b00000_000_0);
  // Mult/div in EX: front end held, bubble into EX/MEM, older stages drain.
  localparam hazard_ctrl_t CTRL_MULDIV  = hazard_ctrl_t'(9'b00011_010_0);
  // Taken branch: fetch target, squash IF/ID and the ID instruction.
  localparam hazard_ctrl_t CTRL_BRANCH  = hazard_ctrl_t'(9'b11111_101_0);
  // Load-use: hold PC and IF/ID, bubble into ID/EX.
  localparam hazard_ctrl_t CTRL_LOADUSE = hazard_ctrl_t'(9'b00111_100_0);

endpackage

// File: rtl/pipeline_stall_controller_load_use_detector.sv
// Load-use hazard compare between the EX-stage load and the ID-stage sources.
module load_use_detector
  import mips_pkg::*;
(
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_reg_rt,
  input  logic [4:0] if_id_reg_rs,
  input  logic [4:0] if_id_reg_rt,
  output logic       load_use_hazard
);

  // A load into $zero never creates a dependency.
  always_comb begin
    load_use_hazard = id_ex_mem_read && (id_ex_reg_rt != REG_ZERO) &&
                      ((id_ex_reg_rt == if_id_reg_rs) || (id_ex_reg_rt == if_id_reg_rt));
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges memory wait,
// multi-cycle mul/div, taken branch and load-use into stage enables.
module pipeline_stall_controller
  import mips_pkg::*;
#(
  parameter int unsigned MULDIV_LAT  = 8,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_reg_rt,
  input  logic [4:0]       if_id_reg_rs,
  input  logic [4:0]       if_id_reg_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_muldiv_start,
  input  logic             ex_mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             if_id_flush,
  output logic             muldiv_busy,
  output logic             muldiv_done,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout_err
);

  localparam logic [7:0]  LAT_M1     = 8'(MULDIV_LAT - 1);
  localparam logic [15:0] TIMEOUT_M1 = 16'(MEM_TIMEOUT - 1);
  localparam logic [15:0] TIMEOUT    = 16'(MEM_TIMEOUT);

  stall_state_e state, state_nx;
  logic [7:0]   md_cnt, md_cnt_nx;
  logic [15:0]  wait_cnt;
  logic         mem_wait;
  logic         load_use_hazard;
  hazard_ctrl_t ctrl;

  load_use_detector u_load_use (
    .id_ex_mem_read  (id_ex_mem_read),
    .id_ex_reg_rt    (id_ex_reg_rt),
    .if_id_reg_rs    (if_id_reg_rs),
    .if_id_reg_rt    (if_id_reg_rt),
    .load_use_hazard (load_use_hazard)
  );

  assign mem_wait = ex_mem_access && !dmem_ready;

  // FSM state and mul/div countdown register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nx;
      md_cnt <= md_cnt_nx;
    end
  end

  // Next state and prioritised control mux: MEMWAIT > MULDIV > BRANCH > LOADUSE.
  // The mul/div start cycle already counts as a stall, so the counter loads
  // LAT-1 and MULDIV finishes when it reaches 1, giving exactly LAT stalls.
  always_comb begin
    ctrl      = CTRL_RUN;
    state_nx  = state;
    md_cnt_nx = md_cnt;
    if (mem_wait) begin
      ctrl = CTRL_FREEZE;
    end else if (state == MULDIV) begin
      ctrl      = CTRL_MULDIV;
      md_cnt_nx = md_cnt - 8'd1;
      if (md_cnt == 8'd1) begin
        ctrl.muldiv_done = 1'b1;
        state_nx         = RUN;
      end
    end else if (ex_muldiv_start) begin
      ctrl      = CTRL_MULDIV;
      state_nx  = MULDIV;
      md_cnt_nx = LAT_M1;
    end else if (ex_branch_taken) begin
      ctrl = CTRL_BRANCH;
    end else if (load_use_hazard) begin
      ctrl = CTRL_LOADUSE;
    end
    if (rst) begin
      ctrl = '0;
    end
  end

  assign pc_write      = ctrl.pc_write;
  assign if_id_write   = ctrl.if_id_write;
  assign id_ex_write   = ctrl.id_ex_write;
  assign ex_mem_write  = ctrl.ex_mem_write;
  assign mem_wb_write  = ctrl.mem_wb_write;
  assign id_ex_bubble  = ctrl.id_ex_bubble;
  assign ex_mem_bubble = ctrl.ex_mem_bubble;
  assign if_id_flush   = ctrl.if_id_flush;
  assign muldiv_done   = ctrl.muldiv_done;
  assign muldiv_busy   = (state == MULDIV) && !rst;

  // Memory wait counter (saturates at the timeout) and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      if (!mem_wait) begin
        wait_cnt <= '0;
      end else if (wait_cnt != TIMEOUT) begin
        wait_cnt <= wait_cnt + 16'd1;
      end
      if (mem_wait && (wait_cnt >= TIMEOUT_M1)) begin
        mem_timeout_err <= 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!pc_write && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller.
module tb_pipeline_stall_controller;

  // Expected control vector bit order:
  // {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
  //  id_ex_bubble, ex_mem_bubble, if_id_flush, muldiv_busy, muldiv_done}
  localparam logic [9:0] E_NORM   = 10'b11111_000_00;
  localparam logic [9:0] E_LU     = 10'b00111_100_00;
  localparam logic [9:0] E_BR     = 10'b11111_101_00;
  localparam logic [9:0] E_FRZ    = 10'b00000_000_00;
  localparam logic [9:0] E_FRZ_B  = 10'b00000_000_10;
  localparam logic [9:0] E_MD_ST  = 10'b00011_010_00;
  localparam logic [9:0] E_MD_B   = 10'b00011_010_10;
  localparam logic [9:0] E_MD_D   = 10'b00011_010_11;

  typedef struct {
    string      name;
    logic       mr;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       br;
    logic       ms;
    logic       ma;
    logic       dr;
    logic [9:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_ex_mem_read;
  logic [4:0]  id_ex_reg_rt;
  logic [4:0]  if_id_reg_rs;
  logic [4:0]  if_id_reg_rt;
  logic        ex_branch_taken;
  logic        ex_muldiv_start;
  logic        ex_mem_access;
  logic        dmem_ready;
  logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic        id_ex_bubble, ex_mem_bubble, if_id_flush;
  logic        muldiv_busy, muldiv_done;
  logic [31:0] stall_count;
  logic        mem_timeout_err;

  logic [9:0]  act;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_stalls = '0;
  logic [9:0]  exp_q[$];
  string       name_q[$];
  vec_t        vecs[$];

  pipeline_stall_controller #(
    .MULDIV_LAT  (8),
    .MEM_TIMEOUT (64),
    .CNT_W       (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_ex_mem_read  (id_ex_mem_read),
    .id_ex_reg_rt    (id_ex_reg_rt),
    .if_id_reg_rs    (if_id_reg_rs),
    .if_id_reg_rt    (if_id_reg_rt),
    .ex_branch_taken (ex_branch_taken),
    .ex_muldiv_start (ex_muldiv_start),
    .ex_mem_access   (ex_mem_access),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .mem_wb_write    (mem_wb_write),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_bubble   (ex_mem_bubble),
    .if_id_flush     (if_id_flush),
    .muldiv_busy     (muldiv_busy),
    .muldiv_done     (muldiv_done),
    .stall_count     (stall_count),
    .mem_timeout_err (mem_timeout_err)
  );

  always #5 clk = ~clk;

  assign act = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                id_ex_bubble, ex_mem_bubble, if_id_flush, muldiv_busy, muldiv_done};

  // Branch and mul/div start must never coincide.
  always @(posedge clk) begin
    if (rst === 1'b0) begin
      assert (!(ex_branch_taken && ex_muldiv_start));
    end
  end

  function automatic vec_t mk(input string n, input logic mr, input logic [4:0] ex_rt,
                              input logic [4:0] id_rs, input logic [4:0] id_rt,
                              input logic br, input logic ms, input logic ma,
                              input logic dr, input logic [9:0] e);
    vec_t v;
    v.name = n; v.mr = mr; v.ex_rt = ex_rt; v.id_rs = id_rs; v.id_rt = id_rt;
    v.br = br; v.ms = ms; v.ma = ma; v.dr = dr; v.exp = e;
    return v;
  endfunction

  task automatic check_val(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare at negedge,
  // then advance past the clock edge and update the stall model.
  task automatic step(input vec_t v);
    logic [9:0] e;
    string      n;
    id_ex_mem_read  = v.mr;
    id_ex_reg_rt    = v.ex_rt;
    if_id_reg_rs    = v.id_rs;
    if_id_reg_rt    = v.id_rt;
    ex_branch_taken = v.br;
    ex_muldiv_start = v.ms;
    ex_mem_access   = v.ma;
    dmem_ready      = v.dr;
    exp_q.push_back(v.exp);
    name_q.push_back(v.name);
    @(negedge clk);
    e = exp_q.pop_front();
    n = name_q.pop_front();
    check_val(n, {22'd0, act}, {22'd0, e});
    @(posedge clk);
    #1;
    if (!e[9]) exp_stalls = exp_stalls + 32'd1;
  endtask

  initial begin
    rst = 1'b1;
    id_ex_mem_read = 0; id_ex_reg_rt = 0; if_id_reg_rs = 0; if_id_reg_rt = 0;
    ex_branch_taken = 0; ex_muldiv_start = 0; ex_mem_access = 0; dmem_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_outputs", {22'd0, act}, 32'd0);
    check_val("reset_stall_count", stall_count, 32'd0);
    check_val("reset_timeout_err", {31'd0, mem_timeout_err}, 32'd0);
    rst = 1'b0;

    // Single-cycle vectors in RUN (order matters only where noted).
    vecs.push_back(mk("idle",            0, 0, 0, 0, 0, 0, 0, 1, E_NORM));
    vecs.push_back(mk("lu_rs5",          1, 5, 5, 0, 0, 0, 0, 1, E_LU));
    vecs.push_back(mk("lu_recover",      0, 5, 5, 0, 0, 0, 0, 1, E_NORM));
    vecs.push_back(mk("lu_zero_reg",     1, 0, 0, 0, 0, 0, 0, 1, E_NORM));
    vecs.push_back(mk("lu_rt7",          1, 7, 0, 7, 0, 0, 0, 1, E_LU));
    vecs.push_back(mk("lu_no_match",     1, 7, 3, 4, 0, 0, 0, 1, E_NORM));
    vecs.push_back(mk("no_load_match",   0, 9, 9, 9, 0, 0, 0, 1, E_NORM));
    vecs.push_back(mk("branch_over_lu",  1, 5, 5, 0, 1, 0, 0, 1, E_BR));
    vecs.push_back(mk("branch_only",     0, 0, 0, 0, 1, 0, 0, 1, E_BR));
    vecs.push_back(mk("mem_ready",       0, 0, 0, 0, 0, 0, 1, 1, E_NORM));
    vecs.push_back(mk("mem_wait",        0, 0, 0, 0, 0, 0, 1, 0, E_FRZ));
    vecs.push_back(mk("memwait_over_lu", 1, 5, 5, 0, 0, 0, 1, 0, E_FRZ));
    vecs.push_back(mk("memwait_over_br", 0, 0, 0, 0, 1, 0, 1, 0, E_FRZ));
    vecs.push_back(mk("memwait_over_md", 0, 0, 0, 0, 0, 1, 1, 0, E_FRZ));
    vecs.push_back(mk("md_not_entered",  0, 0, 0, 0, 0, 0, 0, 1, E_NORM));
    foreach (vecs[i]) step(vecs[i]);
    check_val("stall_count_table", stall_count, exp_stalls);

    // Mul/div: 8 stall cycles, done on the 8th, load-use/start ignored inside.
    step(mk("md_start", 0, 0, 0, 0, 0, 1, 0, 1, E_MD_ST));
    for (int i = 0; i < 6; i++) begin
      if (i == 2) step(mk("md_ignore_lu", 1, 5, 5, 0, 0, 0, 0, 1, E_MD_B));
      else if (i == 3) step(mk("md_ignore_start", 0, 0, 0, 0, 0, 1, 0, 1, E_MD_B));
      else step(mk("md_busy", 0, 0, 0, 0, 0, 0, 0, 1, E_MD_B));
    end
    step(mk("md_done", 0, 0, 0, 0, 0, 0, 0, 1, E_MD_D));
    step(mk("md_after", 0, 0, 0, 0, 0, 0, 0, 1, E_NORM));
    check_val("stall_count_md", stall_count, exp_stalls);

    // Mul/div with a 3-cycle memory wait in the middle: stretched to 11 stalls.
    step(mk("mdw_start", 0, 0, 0, 0, 0, 1, 0, 1, E_MD_ST));
    repeat (2) step(mk("mdw_busy", 0, 0, 0, 0, 0, 0, 0, 1, E_MD_B));
    repeat (3) step(mk("mdw_freeze", 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ_B));
    repeat (4) step(mk("mdw_busy2", 0, 0, 0, 0, 0, 0, 1, 1, E_MD_B));
    step(mk("mdw_done", 0, 0, 0, 0, 0, 0, 0, 1, E_MD_D));
    step(mk("mdw_after", 0, 0, 0, 0, 0, 0, 0, 1, E_NORM));
    check_val("stall_count_mdw", stall_count, exp_stalls);

    // Memory timeout at exactly 64 wait cycles, then sticky.
    repeat (63) step(mk("to_wait", 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ));
    check_val("timeout_not_yet", {31'd0, mem_timeout_err}, 32'd0);
    step(mk("to_wait64", 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ));
    check_val("timeout_set", {31'd0, mem_timeout_err}, 32'd1);
    repeat (3) step(mk("to_after", 0, 0, 0, 0, 0, 0, 0, 1, E_NORM));
    check_val("timeout_sticky", {31'd0, mem_timeout_err}, 32'd1);
    check_val("stall_count_to", stall_count, exp_stalls);

    // Asynchronous reset in the middle of a mul/div.
    step(mk("rmd_start", 0, 0, 0, 0, 0, 1, 0, 1, E_MD_ST));
    repeat (3) step(mk("rmd_busy", 0, 0, 0, 0, 0, 0, 0, 1, E_MD_B));
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_outputs", {22'd0, act}, 32'd0);
    check_val("async_rst_count", stall_count, 32'd0);
    check_val("async_rst_err", {31'd0, mem_timeout_err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_stalls = '0;
    step(mk("post_rst_run", 0, 0, 0, 0, 0, 0, 0, 1, E_NORM));
    step(mk("post_rst_lu", 1, 3, 0, 3, 0, 0, 0, 1, E_LU));
    check_val("post_rst_count", stall_count, exp_stalls);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
